// File: rtl/wb_stage.sv
// Write-back stage: register-file commit plus the CP0 subset.
// Commits exceptions, interrupts and eret, and drives the flush and redirect PC.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY        = 32'hbfc00380,
  parameter int          MS_TO_WS_BUS_WD = 117
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [5:0]                 ext_int_in,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       ex_from_ws,
  output logic [31:0]                ws_new_pc,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  typedef struct packed {
    logic        eret;
    logic        bd;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic        res_from_cp0;
    logic [31:0] rt_value;
    logic        ex;
    logic [4:0]  excode;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_ws_t;

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic        ws_valid;
  logic        ws_ready_go;
  ms_ws_t      ws;

  logic [7:0]  st_im;
  logic        st_exl;
  logic        st_ie;
  logic        c_bd;
  logic        c_ti;
  logic [5:0]  c_iphw;
  logic [1:0]  c_ipsw;
  logic [4:0]  c_code;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;

  logic [7:0]  c_ip;
  logic        int_take;
  logic        commit_ex;
  logic        commit_eret;
  logic        mtc0;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] count_nxt;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] cp0_rdata;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid | ws_ready_go;

  always_ff @(posedge clk) begin
    if (reset)           ws_valid <= 1'b0;
    else if (ex_from_ws) ws_valid <= 1'b0;
    else if (ws_allowin) ws_valid <= ms_to_ws_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ws <= '0;
    else if (ms_to_ws_valid & ws_allowin)
      ws <= ms_to_ws_bus;
  end

  // IP[15] folds the timer into the top hardware line
  assign c_ip     = {c_iphw[5] | c_ti, c_iphw[4:0], c_ipsw};
  assign int_take = st_ie & ~st_exl & |(c_ip & st_im);

  assign commit_ex   = ws_valid & (ws.ex | int_take);
  assign commit_eret = ws_valid & ws.eret & ~commit_ex;
  assign ex_from_ws  = commit_ex | commit_eret;
  assign ws_new_pc   = commit_eret ? epc : EX_ENTRY;

  assign mtc0       = ws_valid & ws.mtc0_we & ~commit_ex;
  assign wr_count   = mtc0 & (ws.cp0_addr == A_COUNT);
  assign wr_compare = mtc0 & (ws.cp0_addr == A_COMPARE);
  assign wr_status  = mtc0 & (ws.cp0_addr == A_STATUS);
  assign wr_cause   = mtc0 & (ws.cp0_addr == A_CAUSE);
  assign wr_epc     = mtc0 & (ws.cp0_addr == A_EPC);

  assign count_nxt = wr_count ? ws.rt_value
                              : count + {31'b0, tick};

  always_ff @(posedge clk) begin
    if (reset) begin
      st_im  <= '0;
      st_exl <= 1'b0;
      st_ie  <= 1'b0;
    end else begin
      if (commit_ex)        st_exl <= 1'b1;
      else if (commit_eret) st_exl <= 1'b0;
      else if (wr_status)   st_exl <= ws.rt_value[1];
      if (wr_status) begin
        st_im <= ws.rt_value[15:8];
        st_ie <= ws.rt_value[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_bd   <= 1'b0;
      c_ti   <= 1'b0;
      c_iphw <= '0;
      c_ipsw <= '0;
      c_code <= '0;
    end else begin
      c_iphw <= ext_int_in;
      if (wr_cause) c_ipsw <= ws.rt_value[9:8];
      if (commit_ex) begin
        c_code <= int_take ? 5'd0 : ws.excode;
        if (!st_exl) c_bd <= ws.bd;
      end
      if (wr_compare)                c_ti <= 1'b0;
      else if (count_nxt == compare) c_ti <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      epc <= '0;
    else if (commit_ex & ~st_exl)
      epc <= ws.bd ? ws.pc - 32'd4 : ws.pc;
    else if (wr_epc)
      epc <= ws.rt_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      tick    <= 1'b0;
      compare <= '0;
    end else begin
      count <= count_nxt;
      tick  <= wr_count ? 1'b0 : ~tick;
      if (wr_compare) compare <= ws.rt_value;
    end
  end

  assign status_rd = {9'b0, 1'b1, 6'b0, st_im,
                      6'b0, st_exl, st_ie};
  assign cause_rd  = {c_bd, c_ti, 14'b0, c_ip,
                      1'b0, c_code, 2'b0};

  always_comb begin
    cp0_rdata = '0;
    unique case (1'b1)
      ws.cp0_addr == A_COUNT:   cp0_rdata = count;
      ws.cp0_addr == A_COMPARE: cp0_rdata = compare;
      ws.cp0_addr == A_STATUS:  cp0_rdata = status_rd;
      ws.cp0_addr == A_CAUSE:   cp0_rdata = cause_rd;
      ws.cp0_addr == A_EPC:     cp0_rdata = epc;
      default:                  cp0_rdata = '0;
    endcase
  end

  // the instruction sitting here during a reset cycle must not write
  assign rf_we    = ws_valid & ws.gr_we & ~commit_ex & ~reset;
  assign rf_waddr = ws.dest;
  assign rf_wdata = ws.res_from_cp0 ? cp0_rdata
                                    : ws.final_result;

  assign debug_wb_pc       = ws.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage. Consumes the memory-stage output bus and commits results to the register file.
- Hosts the CP0 subset: Status, Cause, EPC, Count, Compare.
- Commits exceptions, interrupts and eret. Drives the pipeline-wide flush and the redirect PC to fetch.
- Sits directly downstream of mem_stage; ex_from_ws is that stage's flush input.

Parameters:
EX_ENTRY, 32'hbfc00380, exception/interrupt vector
MS_TO_WS_BUS_WD, 117, width of the incoming bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  out  1  stage can accept a new instruction
ms_to_ws_valid  in  1  mem stage has a valid instruction
ms_to_ws_bus  in  117  {eret[116], bd[115], mtc0_we[114], cp0_addr[113:109], res_from_cp0[108], rt_value[107:76], ex[75], excode[74:70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
ext_int_in  in  6  hardware interrupt lines, level, active-high
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
ex_from_ws  out  1  flush all earlier stages this cycle
ws_new_pc  out  32  redirect target, valid when ex_from_ws=1
debug_wb_pc  out  32  committed PC
debug_wb_rf_wen  out  4  byte enables of rf write, {4{rf_we}}
debug_wb_rf_wnum  out  5  = rf_waddr
debug_wb_rf_wdata  out  32  = rf_wdata

Behaviour:

Pipeline handshake
- ws_ready_go=1. ws_allowin = !ws_valid | ws_ready_go. ws_to_rf path is combinational from the latched bus.
- ws_valid: reset -> 0; else if ex_from_ws -> 0; else if ws_allowin -> ms_to_ws_valid.
- Bus register loads when ms_to_ws_valid & ws_allowin. Contents are don't-care after reset.

Commit and flush
- commit_ex = ws_valid & (ex | int_take). commit_eret = ws_valid & eret & !commit_ex.
- ex_from_ws = commit_ex | commit_eret. ws_new_pc = commit_ex ? EX_ENTRY : EPC.
- rf_we = ws_valid & gr_we & !commit_ex.
- rf_wdata = res_from_cp0 ? cp0_rdata[cp0_addr] : final_result.
- Unimplemented CP0 addresses read 0.
- Reset: all outputs 0 except ws_allowin=1 and ws_new_pc=EX_ENTRY.

Interrupts
- int_take = Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- ExcCode on interrupt = 0; it has priority over the bus excode.
- The interrupted instruction does not commit; EPC = its pc.

CP0 registers (addr)
- Status(12): only IM[15:8], EXL[1], IE[0] are stored. Reset value 32'h0040_0000 (BEV=1 constant). Other bits read 0.
- Cause(13): BD[31], TI[30], IP[15:8], ExcCode[6:2]. Reset value 0.
  - IP[15:10] sampled from ext_int_in every cycle.
  - IP[9:8] are mtc0-writable.
  - IP[15] = ext_int_in[5] | TI.
- EPC(14): reset value 0.
- Count(9): free-running. A tick flop toggles every cycle and Count increments when tick=1, i.e. one increment per 2 cycles.
- Compare(11): reset value 0.
- mtc0 write occurs when ws_valid & mtc0_we & !commit_ex, with data rt_value.
  - Count: write loads the value and clears tick.
  - Compare: write loads the value and clears TI.
  - EPC: write loads the value.
- TI is set when Count==Compare after an update and not written that cycle. TI stays set until Compare is written.

Exception commit (commit_ex)
- EXL <= 1.
- If EXL was 0: EPC <= bd ? pc-4 : pc, and Cause.BD <= bd.
- If EXL was already 1: EPC and BD are unchanged.
- Cause.ExcCode <= int_take ? 0 : excode.

Eret commit
- EXL <= 0; redirect to the old EPC.

Simultaneous events
- Exception and mtc0 in the same instruction: the exception wins and there is no write.
- mtc0 Status/Cause and hardware update in the same cycle: commit_ex fields take priority, then mtc0, then the hardware IP sampling. ext_int sampling always applies.
- Reset mid-operation: ws_valid cleared, CP0 returns to reset values, no rf write that cycle.

Test Plan:
1. ALU commit: bus {gr_we=1, dest=5, final_result=32'h1234, pc=32'hbfc00100} -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234, debug_wb_rf_wen=4'hf.
2. Syscall, bd=0: ex=1, excode=8, pc=32'hbfc00200 -> ex_from_ws=1, ws_new_pc=32'hbfc00380, rf_we=0; then EPC=32'hbfc00200, Cause.ExcCode=8, Status.EXL=1, ws_valid=0.
3. Exception in delay slot: bd=1, pc=32'hbfc00304 -> EPC=32'hbfc00300, Cause.BD=1. A second exception while EXL=1 leaves EPC unchanged.
4. Eret: EPC=32'hbfc00500, eret=1 -> ex_from_ws=1, ws_new_pc=32'hbfc00500; EXL=0 next cycle.
5. Timer: mtc0 Compare=10, mtc0 Count=8, Status={IM7=1, IE=1} -> TI=1 after 4 cycles. Next valid instruction gets ExcCode=0, redirect to 32'hbfc00380. mtc0 Compare clears TI.
6. mfc0 and mtc0 precedence: mfc0 Cause while ext_int_in=6'b000001 -> rf_wdata[10]=1. mtc0 Cause.IP[8]=1 with ex=1 -> IP[8] stays 0. Assert reset mid-stream -> Status=32'h00400000, rf_we=0.
